ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter AW, default 8: RAM address width; depth is 2**AW (256).
REQ-002 Parameter DW, default 4: data width.
REQ-003 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port push  input  1: write request.
REQ-006 Port push_data  input  DW: data to enqueue.
REQ-007 Port push_ready  output  1: combinational; high when a push this cycle is accepted.
REQ-008 Port pop  input  1: read request.
REQ-009 Port pop_data  output  DW: registered dequeued data.
REQ-010 Port pop_valid  output  1: registered; pop_data valid this cycle.
REQ-011 Port full  output  1: count == 2**AW.
REQ-012 Port empty  output  1: count == 0.
REQ-013 Port count  output  AW+1: current occupancy, 0..256.
REQ-014 Port overflow  output  1: sticky; a push was refused because the FIFO was full.
REQ-015 Port underflow  output  1: sticky; a pop was refused because the FIFO was empty.
REQ-016 Port ram_we  output  1: single-port RAM write enable.
REQ-017 Port ram_addr  output  AW: RAM address.
REQ-018 Port ram_wdata  output  DW: RAM write data.
REQ-019 Port ram_rdata  input  DW: RAM asynchronous read data for ram_addr.

Function
REQ-020 The block SHALL keep registered wr_ptr and rd_ptr (AW bits each) and count (AW+1 bits).
REQ-021 pop_acc SHALL equal pop AND NOT empty AND NOT rst.
REQ-022 push_acc SHALL equal push AND NOT full AND NOT pop_acc AND NOT rst.
REQ-023 Consequence of REQ-021/022: pop has priority over push because the RAM is single-port; push_ready SHALL equal NOT full AND NOT pop_acc AND NOT rst.
REQ-024 ram_addr SHALL equal rd_ptr when pop_acc is high, else wr_ptr.
REQ-025 ram_we SHALL equal push_acc, and ram_wdata SHALL equal push_data.
REQ-026 On push_acc: wr_ptr SHALL increment and count SHALL increment.
REQ-027 On pop_acc: pop_data SHALL load ram_rdata, rd_ptr SHALL increment and count SHALL decrement.
REQ-028 pop_valid SHALL be high in the cycle after each pop_acc (1-cycle latency), otherwise low.
REQ-029 pop_data SHALL hold its value when there is no pop_acc.
REQ-030 Pointers SHALL wrap modulo 2**AW (255 -> 0).
REQ-031 count SHALL never exceed 256 and never go below 0.
REQ-032 Push while full SHALL leave pointers, count and RAM unchanged, and SHALL set overflow.
REQ-033 Pop while empty SHALL leave state unchanged, SHALL set underflow, and SHALL leave pop_valid low the next cycle, including when push is asserted in the same cycle.
REQ-034 Push and pop together while empty: the push SHALL be accepted and the pop refused per REQ-033.
REQ-035 Push and pop together while full: the pop SHALL be accepted, the push refused, and overflow SHALL be set.
REQ-036 overflow and underflow SHALL clear only on rst.

Reset
REQ-037 With rst high at a clock edge: wr_ptr, rd_ptr and count SHALL be 0, pop_data SHALL be 0, and pop_valid, overflow and underflow SHALL be 0.
REQ-038 After reset, empty SHALL be 1 and full SHALL be 0.
REQ-039 While rst is high, ram_we SHALL be 0 and push and pop SHALL be ignored.
REQ-040 RAM contents are not cleared by reset.
REQ-041 Reset asserted mid-operation SHALL discard all queued data.

Verification
REQ-042 Reset, push 0x3, 0x5, 0xA -> count=3; three pops -> pop_valid with pop_data 0x3, 0x5, 0xA, each one cycle after its pop.
REQ-043 256 pushes of i[3:0] -> full=1, count=256; a 257th push -> ram_we=0, push_ready=0, overflow=1, count=256.
REQ-044 count=2, push and pop in the same cycle -> ram_addr=rd_ptr, ram_we=0, count=1, pop_valid next cycle.
REQ-045 Empty FIFO, push 0x7 and pop in the same cycle -> push accepted, count=1, underflow=1, pop_valid=0 next cycle.
REQ-046 300 alternating push/pop pairs -> pointers wrap past 255, every popped value equals the value pushed in order, count returns to 0.
REQ-047 count=5, rst pulsed for one cycle with pop high -> next cycle count=0, empty=1, pop_valid=0, overflow=0, underflow=0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : FIFO controller for an external single-port RAM with
//               asynchronous read; pop has priority over push.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0]   c_FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   c_CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE    = AW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_pop_data;
  logic          r_pop_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;

  assign w_full  = (r_count == c_FULL_COUNT);
  assign w_empty = (r_count == '0);

  // The RAM has one port, so an accepted pop takes it and blocks any push.
  assign w_pop_acc  = pop & ~w_empty & ~rst;
  assign w_push_acc = push & ~w_full & ~w_pop_acc & ~rst;

  assign push_ready = ~w_full & ~w_pop_acc & ~rst;
  assign ram_we     = w_push_acc;
  assign ram_wdata  = push_data;
  assign ram_addr   = w_pop_acc ? r_rd_ptr : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_acc;
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        r_count  <= r_count + c_CNT_ONE;
      end else if (w_pop_acc) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
        r_count    <= r_count - c_CNT_ONE;
        r_pop_data <= ram_rdata;
      end
      // Sticky flags only note refusals caused by occupancy, not by arbitration.
      if (push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Directed self-checking bench for ram_fifo_ctrl with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_fifo_ctrl;

  localparam int AW = 8;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          push;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [2**AW];

  int n_checks;
  int n_errors;

  ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop        (pop),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] vec [3];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    vec[0] = 4'h3; vec[1] = 4'h5; vec[2] = 4'hA;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_pop_valid", 32'(pop_valid), 0);
    check("rst_pop_data", 32'(pop_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_push_ready", 32'(push_ready), 1);

    // Three pushes then three back-to-back pops
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_data = vec[i];
      #1;
      check("push_we", 32'(ram_we), 1);
      check("push_addr", 32'(ram_addr), 32'(i));
      tick();
    end
    push = 1'b0;
    #1;
    check("three_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      #1;
      check("pop_nowe", 32'(ram_we), 0);
      tick();
      check("pop_valid", 32'(pop_valid), 1);
      check("pop_data", 32'(pop_data), 32'(vec[i]));
    end
    pop = 1'b0;
    tick();
    check("pop_valid_low", 32'(pop_valid), 0);
    check("drained_empty", 32'(empty), 1);
    check("pop_data_hold", 32'(pop_data), 32'hA);

    // Push and pop together while empty: push wins, pop is refused
    push = 1'b1; pop = 1'b1; push_data = 4'h7;
    #1;
    check("pe_push_ready", 32'(push_ready), 1);
    check("pe_we", 32'(ram_we), 1);
    check("pe_addr", 32'(ram_addr), 3);
    tick();
    push = 1'b0; pop = 1'b0;
    #1;
    check("pe_count", 32'(count), 1);
    check("pe_underflow", 32'(underflow), 1);
    check("pe_pop_valid", 32'(pop_valid), 0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("pe_drain_valid", 32'(pop_valid), 1);
    check("pe_drain_data", 32'(pop_data), 7);

    // count=2, simultaneous push and pop: pop takes the RAM
    push = 1'b1; push_data = 4'h1; tick();
    push_data = 4'h2; tick();
    pop = 1'b1; push_data = 4'h9;
    #1;
    check("pp_count2", 32'(count), 2);
    check("pp_we", 32'(ram_we), 0);
    check("pp_push_ready", 32'(push_ready), 0);
    check("pp_addr_rd", 32'(ram_addr), 4);
    tick();
    push = 1'b0;
    check("pp_count", 32'(count), 1);
    check("pp_valid", 32'(pop_valid), 1);
    check("pp_data", 32'(pop_data), 1);
    tick();
    pop = 1'b0;
    check("pp_data2", 32'(pop_data), 2);
    check("pp_empty", 32'(empty), 1);

    // count=5, one-cycle reset with pop high
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = DW'(i + 3);
      tick();
    end
    push = 1'b0;
    #1;
    check("mr_count5", 32'(count), 5);
    rst = 1'b1; pop = 1'b1;
    #1;
    check("mr_we", 32'(ram_we), 0);
    check("mr_push_ready", 32'(push_ready), 0);
    tick();
    rst = 1'b0; pop = 1'b0;
    #1;
    check("mr_count", 32'(count), 0);
    check("mr_empty", 32'(empty), 1);
    check("mr_pop_valid", 32'(pop_valid), 0);
    check("mr_overflow", 32'(overflow), 0);
    check("mr_underflow", 32'(underflow), 0);

    // 300 alternating push/pop pairs across the pointer wrap
    for (int i = 0; i < 300; i++) begin
      push = 1'b1; push_data = DW'(i);
      tick();
      push = 1'b0; pop = 1'b1;
      tick();
      pop = 1'b0;
      check("alt_valid", 32'(pop_valid), 1);
      check("alt_data", 32'(pop_data), 32'(i % 16));
    end
    #1;
    check("alt_count", 32'(count), 0);
    check("alt_wrap_addr", 32'(ram_addr), 44);

    // Fill to full, then overflow attempts
    push = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_data = DW'(i);
      tick();
    end
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 256);
    check("fill_overflow0", 32'(overflow), 0);
    push_data = 4'hF;
    #1;
    check("of_we", 32'(ram_we), 0);
    check("of_push_ready", 32'(push_ready), 0);
    tick();
    check("of_overflow", 32'(overflow), 1);
    check("of_count", 32'(count), 256);
    pop = 1'b1;
    #1;
    check("fp_we", 32'(ram_we), 0);
    check("fp_addr", 32'(ram_addr), 44);
    tick();
    push = 1'b0;
    check("fp_count", 32'(count), 255);
    check("fp_valid", 32'(pop_valid), 1);
    check("fp_data", 32'(pop_data), 0);
    for (int i = 1; i < 256; i++) begin
      tick();
      check("drain_data", 32'(pop_data), 32'(i % 16));
    end
    #1;
    check("drain_empty", 32'(empty), 1);
    check("drain_underflow0", 32'(underflow), 0);
    tick();
    pop = 1'b0;
    check("uf_valid", 32'(pop_valid), 0);
    check("uf_underflow", 32'(underflow), 1);
    check("uf_overflow_sticky", 32'(overflow), 1);
    check("uf_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
